// File: rtl/horner_poly_eval.sv
// Handshaked Horner polynomial evaluator with a run-time writable coefficient bank.
// One rounded, saturating multiply-accumulate per cycle; sticky overflow per result.
module horner_poly_eval #(
    parameter int WL  = 16,
    parameter int XF  = 14,
    parameter int CL  = 16,
    parameter int CF  = 14,
    parameter int GB  = 4,
    parameter int OW  = 16,
    parameter int DEG = 4,
    localparam int AW = CL + GB,
    localparam int AD = $clog2(DEG + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          coeff_we_i,
    input  logic [AD-1:0] coeff_addr_i,
    input  logic [CL-1:0] coeff_wdata_i,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic [WL-1:0] data_in_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [OW-1:0] data_out_o,
    output logic          ovf_o
);

    localparam int PW = AW + WL;
    localparam logic [AD-1:0] DEG_A = AD'(DEG);
    localparam logic [AD-1:0] KTOP = AD'(DEG - 1);
    localparam logic signed [PW:0] HALF = (PW + 1)'(1) << (XF - 1);
    localparam logic signed [AW-1:0] AMAX = {1'b0, {(AW - 1){1'b1}}};
    localparam logic signed [AW-1:0] AMIN = {1'b1, {(AW - 1){1'b0}}};
    localparam logic [OW-1:0] OMAX = {1'b0, {(OW - 1){1'b1}}};
    localparam logic [OW-1:0] OMIN = {1'b1, {(OW - 1){1'b0}}};

    if (XF < 1 || XF >= WL || OW > AW || DEG < 1 || CF < 0 || GB < 1) begin : g_bad_param
        $error("horner_poly_eval: illegal parameter set");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_OUT
    } state_t;

    state_t                  state_q, state_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [WL-1:0]    x_q, x_d;
    logic        [AD-1:0]    k_q, k_d;
    logic                    flg_q, flg_d;
    logic        [OW-1:0]    dout_q, dout_d;
    logic                    ovf_q, ovf_d;
    logic signed [CL-1:0]    coef_q [DEG+1];
    logic signed [CL-1:0]    coef_d [DEG+1];

    logic signed [PW:0]      prod_w, rnd_w, sh_w;
    logic        [PW-AW+1:0] top_w;
    logic signed [AW-1:0]    mul_s, step_s;
    logic signed [CL-1:0]    ck_w;
    logic        [AW:0]      sum_w;
    logic        [AW-OW:0]   otop_w;
    logic        [OW-1:0]    out_s;
    logic                    clip1, clip2, clip3;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        x_d     = x_q;
        k_d     = k_q;
        flg_d   = flg_q;
        dout_d  = dout_q;
        ovf_d   = ovf_q;
        coef_d  = coef_q;

        // Exact product, round-half-up, then clamp into the accumulator.
        prod_w = (PW + 1)'(acc_q) * (PW + 1)'(x_q);
        rnd_w  = prod_w + HALF;
        sh_w   = rnd_w >>> XF;
        top_w  = sh_w[PW:AW-1];
        clip1  = !((&top_w) || !(|top_w));
        mul_s  = clip1 ? (sh_w[PW] ? AMIN : AMAX) : sh_w[AW-1:0];

        ck_w   = coef_q[k_q];
        sum_w  = {mul_s[AW-1], mul_s} + (AW + 1)'(ck_w);
        clip2  = sum_w[AW] ^ sum_w[AW-1];
        step_s = clip2 ? (sum_w[AW] ? AMIN : AMAX) : sum_w[AW-1:0];

        otop_w = step_s[AW-1:OW-1];
        clip3  = !((&otop_w) || !(|otop_w));
        out_s  = clip3 ? (step_s[AW-1] ? OMIN : OMAX) : step_s[OW-1:0];

        unique case (state_q)
            S_IDLE: begin
                if (coeff_we_i && coeff_addr_i <= DEG_A) begin
                    coef_d[coeff_addr_i] = coeff_wdata_i;
                end
                if (in_valid_i) begin
                    x_d     = data_in_i;
                    acc_d   = AW'(coef_q[DEG]);
                    k_d     = KTOP;
                    flg_d   = 1'b0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                acc_d = step_s;
                flg_d = flg_q | clip1 | clip2;
                if (k_q == '0) begin
                    dout_d  = out_s;
                    ovf_d   = flg_q | clip1 | clip2 | clip3;
                    state_d = S_OUT;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            S_OUT: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            x_q     <= '0;
            k_q     <= '0;
            flg_q   <= 1'b0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            for (int i = 0; i <= DEG; i++) begin
                coef_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            k_q     <= k_d;
            flg_q   <= flg_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            coef_q  <= coef_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_OUT);
    assign data_out_o  = dout_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_horner_poly_eval.sv
// Scoreboard bench for horner_poly_eval: reference Horner model in longint
// arithmetic, expected results queued at accept and compared at output.
module tb_horner_poly_eval;

    localparam int WL  = 16;
    localparam int XF  = 14;
    localparam int CL  = 16;
    localparam int OW  = 16;
    localparam int DEG = 4;
    localparam int AW  = 20;
    localparam int AD  = 3;

    localparam longint AMAX = (longint'(1) << (AW - 1)) - 1;
    localparam longint AMIN = -(longint'(1) << (AW - 1));
    localparam longint OMAX = (longint'(1) << (OW - 1)) - 1;
    localparam longint OMIN = -(longint'(1) << (OW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coeff_we = 1'b0;
    logic [AD-1:0] coeff_addr = '0;
    logic [CL-1:0] coeff_wdata = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [WL-1:0] data_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [OW-1:0] data_out;
    logic          ovf;

    int total = 0;
    int bad   = 0;

    longint         cm [DEG+1];
    logic   [OW:0]  sbq [$];

    horner_poly_eval dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .coeff_we_i   (coeff_we),
        .coeff_addr_i (coeff_addr),
        .coeff_wdata_i(coeff_wdata),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .data_in_i    (data_in),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .data_out_o   (data_out),
        .ovf_o        (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [OW:0] model(input longint xv);
        longint acc;
        longint p;
        bit     f;
        logic [OW-1:0] d;
        acc = cm[DEG];
        f   = 1'b0;
        for (int k = DEG - 1; k >= 0; k--) begin
            p = acc * xv;
            p = (p + (longint'(1) << (XF - 1))) >>> XF;
            if (p > AMAX) begin p = AMAX; f = 1'b1; end
            else if (p < AMIN) begin p = AMIN; f = 1'b1; end
            p = p + cm[k];
            if (p > AMAX) begin p = AMAX; f = 1'b1; end
            else if (p < AMIN) begin p = AMIN; f = 1'b1; end
            acc = p;
        end
        if (acc > OMAX) begin acc = OMAX; f = 1'b1; end
        else if (acc < OMIN) begin acc = OMIN; f = 1'b1; end
        d = OW'(acc);
        return {f, d};
    endfunction

    task automatic set_coef(input int k, input int v);
        @(negedge clk);
        coeff_we    = 1'b1;
        coeff_addr  = AD'(k);
        coeff_wdata = CL'(v);
        @(negedge clk);
        coeff_we = 1'b0;
        if (k <= DEG) cm[k] = longint'(v);
    endtask

    task automatic start_eval(input int xv);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        data_in  = WL'(xv);
        sbq.push_back(model(longint'(xv)));
        @(negedge clk);
        in_valid = 1'b0;
        data_in  = WL'($urandom);
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== '0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got v=%b r=%b d=%0d o=%b want 0 1 0 0",
                     out_valid, in_ready, data_out, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        logic [OW:0] exp;
        set_coef(0, 16384);
        set_coef(1, 16384);
        start_eval(8192);
        wait_out(cyc);
        exp = sbq.pop_front();
        total++;
        if (cyc !== DEG) begin
            bad++;
            $display("FAIL basic_latency: got %0d want %0d", cyc, DEG);
        end
        total++;
        if (data_out !== 16'd24576 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL basic_value: got %0d/%b want 24576/0", data_out, ovf);
        end
        total++;
        if ({ovf, data_out} !== exp) begin
            bad++;
            $display("FAIL basic_model: got %h want %h", {ovf, data_out}, exp);
        end
        ack();
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_release: got v=%b r=%b want 0 1", out_valid, in_ready);
        end
        set_coef(7, 1234);
        start_eval(8192);
        wait_out(cyc);
        exp = sbq.pop_front();
        total++;
        if (data_out !== 16'd24576 || {ovf, data_out} !== exp) begin
            bad++;
            $display("FAIL addr_range: got %0d want 24576", data_out);
        end
        ack();
    endtask

    task automatic test_round();
        int cyc;
        logic [OW:0] exp;
        set_coef(0, 0);
        set_coef(1, 8192);
        start_eval(1);
        wait_out(cyc);
        exp = sbq.pop_front();
        total++;
        if (data_out !== 16'd1 || ovf !== 1'b0 || {ovf, data_out} !== exp) begin
            bad++;
            $display("FAIL round_pos: got %0d/%b want 1/0", data_out, ovf);
        end
        ack();
        set_coef(1, -8192);
        start_eval(1);
        wait_out(cyc);
        exp = sbq.pop_front();
        total++;
        if (data_out !== 16'd0 || ovf !== 1'b0 || {ovf, data_out} !== exp) begin
            bad++;
            $display("FAIL round_neg: got %0d/%b want 0/0", data_out, ovf);
        end
        ack();
    endtask

    task automatic test_saturation();
        int cyc;
        logic [OW:0] exp;
        for (int k = 0; k <= DEG; k++) set_coef(k, 32767);
        start_eval(32767);
        wait_out(cyc);
        exp = sbq.pop_front();
        total++;
        if (data_out !== 16'd32767 || ovf !== 1'b1 || {ovf, data_out} !== exp) begin
            bad++;
            $display("FAIL sat_clip: got %0d/%b want 32767/1", data_out, ovf);
        end
        ack();
        start_eval(0);
        wait_out(cyc);
        exp = sbq.pop_front();
        total++;
        if (data_out !== 16'd32767 || ovf !== 1'b0 || {ovf, data_out} !== exp) begin
            bad++;
            $display("FAIL sat_clean: got %0d/%b want 32767/0", data_out, ovf);
        end
        ack();
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [OW:0] exp;
        set_coef(0, 1000);
        set_coef(1, 2000);
        set_coef(2, -3000);
        set_coef(3, 500);
        set_coef(4, 100);
        start_eval(5000);
        wait_out(cyc);
        exp = sbq.pop_front();
        total++;
        if ({ovf, data_out} !== exp) begin
            bad++;
            $display("FAIL bp_first: got %h want %h", {ovf, data_out}, exp);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid    = 1'b1;
            data_in     = WL'(-7000);
            coeff_we    = 1'b1;
            coeff_addr  = AD'(1);
            coeff_wdata = CL'(-20000);
            @(negedge clk);
            total++;
            if ({ovf, data_out} !== exp || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold%0d: got %h r=%b v=%b want %h 0 1",
                         i, {ovf, data_out}, in_ready, out_valid, exp);
            end
        end
        in_valid  = 1'b0;
        coeff_we  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_release: got r=%b v=%b want 1 0", in_ready, out_valid);
        end
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_no_extra: got v=%b r=%b want 0 1", out_valid, in_ready);
        end
        start_eval(5000);
        wait_out(cyc);
        total++;
        if (cyc !== DEG || {ovf, data_out} !== sbq.pop_front() || {ovf, data_out} !== exp) begin
            bad++;
            $display("FAIL bp_next: got %h lat=%0d want %h lat=%0d", {ovf, data_out}, cyc, exp, DEG);
        end
        ack();
    endtask

    task automatic test_reset_mid();
        int cyc;
        logic [OW:0] exp;
        start_eval(3000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== '0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid: got v=%b r=%b d=%0d o=%b want 0 1 0 0",
                     out_valid, in_ready, data_out, ovf);
        end
        sbq.delete();
        for (int k = 0; k <= DEG; k++) cm[k] = 0;
        @(negedge clk);
        rst = 1'b0;
        start_eval(12345);
        wait_out(cyc);
        exp = sbq.pop_front();
        total++;
        if (cyc !== DEG || data_out !== '0 || ovf !== 1'b0 || {ovf, data_out} !== exp) begin
            bad++;
            $display("FAIL rst_after: got %0d/%b lat=%0d want 0/0 lat=%0d", data_out, ovf, cyc, DEG);
        end
        ack();
    endtask

    task automatic test_back_to_back();
        int xs [3];
        int idx;
        int got;
        int last;
        logic [OW:0] exp;
        xs = '{6000, -16384, 11111};
        set_coef(0, -5000);
        set_coef(1, 12000);
        set_coef(2, 3000);
        set_coef(3, -8000);
        set_coef(4, 4000);
        idx  = 0;
        got  = 0;
        last = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 80 && got < 3; c++) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (sbq.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_extra: got %h want none", {ovf, data_out});
                end else begin
                    exp = sbq.pop_front();
                    if ({ovf, data_out} !== exp) begin
                        bad++;
                        $display("FAIL b2b_value%0d: got %h want %h", got, {ovf, data_out}, exp);
                    end
                end
                if (got > 0) begin
                    total++;
                    if (c - last !== DEG + 2) begin
                        bad++;
                        $display("FAIL b2b_spacing%0d: got %0d want %0d", got, c - last, DEG + 2);
                    end
                end
                last = c;
                got++;
            end
            if (in_ready) begin
                if (idx < 3) begin
                    in_valid = 1'b1;
                    data_in  = WL'(xs[idx]);
                    sbq.push_back(model(longint'(xs[idx])));
                    idx++;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                data_in = WL'($urandom);
            end
        end
        total++;
        if (got !== 3) begin
            bad++;
            $display("FAIL b2b_timeout: got %0d results want 3", got);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
    endtask

    initial begin
        for (int k = 0; k <= DEG; k++) cm[k] = 0;
        test_reset();
        test_basic();
        test_round();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/horner_poly_eval.md
# horner_poly_eval

Parametrised, handshaked polynomial evaluator. It computes p(x) = c0 + c1·x + … + cDEG·x^DEG by sequential Horner iteration, at one multiply-accumulate per cycle. Coefficients sit in an internal writable bank, so a Chebyshev-derived or any other fitted polynomial of configurable degree can be loaded at run time. The block replaces the fixed-degree, free-running Chebyshev datapath with a controlled engine that has these features:

- valid/ready handshakes on input and output;
- round-half-up after every product;
- saturation;
- a per-result overflow flag.

## Interface
- WL, 16, input word length (signed)
- XF, 14, fractional bits of x (1 ≤ XF < WL)
- CL, 16, coefficient length (signed, CF fractional bits)
- CF, 14, fractional bits of coefficients, accumulator and output
- GB, 4, accumulator guard bits; AW = CL + GB
- OW, 16, output width (OW ≤ AW)
- DEG, 4, polynomial degree (DEG ≥ 1); AD = clog2(DEG+1)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- coeff_we  in  1  coefficient write strobe
- coeff_addr  in  AD  coefficient index k (0..DEG)
- coeff_wdata  in  CL  coefficient value ck
- in_valid  in  1  x offered
- in_ready  out  1  block can accept x (high only in IDLE)
- data_in  in  WL  x, signed, XF fractional bits
- out_valid  out  1  result available
- out_ready  in  1  consumer accepts result
- data_out  out  OW  p(x), signed, CF fractional bits
- ovf  out  1  saturation occurred during this result

## Operation
- Coefficient bank: DEG+1 registers of CL bits.
  - Written on a clock edge when coeff_we=1, coeff_addr ≤ DEG and the state is IDLE.
  - Writes are dropped in any other state, or when coeff_addr > DEG.
  - All registers clear to 0 on reset.
- FSM has three states: IDLE, ITER and OUT.
  - IDLE: in_ready=1. On in_valid=1, capture x, set acc ← sign-extend(cDEG), set k ← DEG−1, clear the internal overflow flag, and go to ITER.
  - ITER: one step per cycle, acc ← S_AW(S_AW(R(acc·x)) + sext(ck)), then k ← k−1. After the step with k=0, load data_out ← S_OW(result), load ovf ← the accumulated flag, and go to OUT.
  - OUT: out_valid=1, with data_out and ovf held stable. On out_ready=1, go to IDLE.
- Arithmetic:
  - The product acc·x is exact, AW+WL bits wide, with CF+XF fractional bits.
  - R(·) adds 2^(XF−1) and then shifts arithmetic-right by XF. This is round-half-up, so ties round toward +∞.
  - S_n(·) clamps to [−2^(n−1), 2^(n−1)−1].
  - The coefficient add is done in AW+1 bits before clamping.
  - The internal flag is set whenever any of the three saturations in a step, or the final S_OW, actually clips its value.
- in_valid is ignored outside IDLE. data_in is sampled only on the accept edge, so later changes to it do not affect the result.
- in_ready is decoded combinationally from the state register and has no path from out_ready.
- Reset mid-operation: the FSM returns to IDLE immediately. The partial result is discarded, all outputs go to reset values and the bank clears.

## Timing
- Reset values:
  - out_valid=0, data_out=0, ovf=0;
  - in_ready=1 (IDLE);
  - internal acc, x and k = 0.
- Latency:
  - Accept edge E0.
  - ITER steps occur on edges E1..EDEG.
  - out_valid rises after edge EDEG, so DEG cycles after acceptance.
- Throughput: one result per DEG+2 cycles at best. There is one OUT cycle with out_ready=1, then one IDLE cycle before the next accept.
- The output handshake completes on the edge where out_valid=1 and out_ready=1. out_valid is 0 in the following cycle.
- A coeff_we on the same edge as acceptance is applied, because the state is still IDLE. The new value is visible to that evaluation if k<DEG, but not for cDEG, which was already loaded.

## Test plan
- Basic evaluation, default parameters:
  - Stimulus: c0=16384, c1=16384, c2..c4=0, x=8192 (0.5).
  - Required response: out_valid 4 cycles after accept, data_out=24576 (1.5), ovf=0.
- Rounding tie:
  - Stimulus: c1=8192, all others 0, x=1.
  - Required response: data_out=1.
  - Stimulus: c1=−8192, x=1.
  - Required response: data_out=0, ovf=0.
- Saturation:
  - Stimulus: all ck=32767, x=32767.
  - Required response: accumulator clips at 524287, data_out=32767, ovf=1. The next clean evaluation returns ovf=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles, pulse in_valid throughout, and pulse coeff_we with a new c1.
  - Required response: data_out and ovf held, in_ready=0, neither the second x nor the write takes effect. After out_ready=1 the FSM is in IDLE and the next accept proceeds.
- Reset mid-operation:
  - Stimulus: assert reset during the second ITER cycle.
  - Required response: out_valid=0, in_ready=1, data_out=0 immediately. A subsequent evaluation with the bank still unwritten returns 0.
- Back-to-back:
  - Stimulus: hold in_valid=1 and out_ready=1 over three x values.
  - Required response: results in order, spaced DEG+2 cycles apart, each matching a Horner reference model to the bit.
